// File: rtl/clap_mem_pkg.sv
// Shared types and constants for the D-cache request controller.
package clap_mem_pkg;

  localparam int unsigned EXP_W  = 7;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] SC_SUCCESS = DATA_W'(1);
  localparam logic [DATA_W-1:0] SC_FAILURE = DATA_W'(0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_SC_FAIL = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  // Request fields latched when a requester is granted.
  typedef struct packed {
    logic              cacop;
    logic [CODE_W-1:0] code;
    logic              op;
    logic              atom;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/clap_llbit.sv
// LL/SC reservation bit: LL sets it, SC consumes it, an explicit clear
// overrides a concurrent set.
module clap_llbit (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic sc_consume,
  input  logic clr,
  output logic llbit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      llbit <= 1'b0;
    end else if (clr || sc_consume) begin
      llbit <= 1'b0;
    end else if (set) begin
      llbit <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_req_ctrl.sv
// Arbitrates the single D-cache port between the LSU and CACOP, holds the
// request until accepted, and returns completion, data and exceptions.
module dcache_req_ctrl
  import clap_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_op,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [STRB_W-1:0] lsu_wstrb,
  input  logic              lsu_atom,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [EXP_W-1:0]  lsu_exp,
  input  logic              cacop_req,
  input  logic [ADDR_W-1:0] cacop_addr,
  input  logic [CODE_W-1:0] cacop_code,
  output logic              cacop_ready,
  output logic              cacop_done,
  input  logic              flush,
  input  logic              llbit_clr,
  output logic              llbit,
  output logic              c_valid,
  output logic              c_op,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic [STRB_W-1:0] c_wstrb,
  output logic              c_atom,
  output logic              c_cacop,
  output logic [CODE_W-1:0] c_cacop_code,
  input  logic              c_accept,
  input  logic              c_data_valid,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic [EXP_W-1:0]  c_exception,
  output logic              stall
);

  state_t state, state_nx;
  req_t   req_q, req_nx;
  logic   has_exc;
  logic   fin;
  logic   llbit_set;
  logic   llbit_sc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      req_q <= '0;
    end else begin
      state <= state_nx;
      req_q <= req_nx;
    end
  end

  // Cache port presents the latched request only while waiting for acceptance.
  assign c_valid      = (state == S_REQ);
  assign c_op         = req_q.op;
  assign c_addr       = req_q.addr;
  assign c_wdata      = req_q.wdata;
  assign c_wstrb      = req_q.wstrb;
  assign c_atom       = req_q.atom;
  assign c_cacop      = req_q.cacop;
  assign c_cacop_code = req_q.code;

  assign has_exc = |c_exception;

  always_comb begin
    state_nx    = state;
    req_nx      = req_q;
    lsu_ready   = 1'b0;
    cacop_ready = 1'b0;
    lsu_done    = 1'b0;
    cacop_done  = 1'b0;
    lsu_rdata   = '0;
    lsu_exp     = '0;
    llbit_set   = 1'b0;
    llbit_sc    = 1'b0;
    fin         = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rst && !flush) begin
          if (cacop_req) begin
            cacop_ready = 1'b1;
            req_nx      = '{cacop: 1'b1, code: cacop_code, op: 1'b0, atom: 1'b0,
                            addr: cacop_addr, wdata: '0, wstrb: '0};
            state_nx    = S_REQ;
          end else if (lsu_req) begin
            lsu_ready = 1'b1;
            req_nx    = '{cacop: 1'b0, code: '0, op: lsu_op, atom: lsu_atom,
                          addr: lsu_addr, wdata: lsu_wdata, wstrb: lsu_wstrb};
            // An SC without a reservation fails locally without a cache access.
            state_nx  = (lsu_atom && lsu_op && !llbit) ? S_SC_FAIL : S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_nx = S_IDLE;
        end else if (has_exc) begin
          fin      = 1'b1;
          state_nx = S_IDLE;
        end else if (c_accept) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (c_data_valid || has_exc) begin
          fin      = !flush;
          state_nx = S_IDLE;
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (c_data_valid || has_exc) begin
          state_nx = S_IDLE;
        end
      end
      S_SC_FAIL: begin
        lsu_done  = !flush;
        lsu_rdata = SC_FAILURE;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Completion reporting and reservation update for the finished request.
    if (fin) begin
      if (req_q.cacop) begin
        cacop_done = 1'b1;
      end else begin
        lsu_done = 1'b1;
        lsu_exp  = c_exception;
        if (!has_exc) begin
          if (req_q.atom && req_q.op) begin
            lsu_rdata = SC_SUCCESS;
            llbit_sc  = 1'b1;
          end else begin
            lsu_rdata = c_data_valid ? c_rdata : '0;
            llbit_set = req_q.atom;
          end
        end
      end
    end
  end

  assign stall = ((state != S_IDLE) | lsu_req) & ~lsu_done & ~cacop_done;

  clap_llbit u_llbit (
    .clk        (clk),
    .rst        (rst),
    .set        (llbit_set),
    .sc_consume (llbit_sc),
    .clr        (llbit_clr),
    .llbit      (llbit)
  );

endmodule

// File: tb/tb_dcache_req_ctrl.sv
// Self-checking bench for dcache_req_ctrl with a transaction-level LL/SC model.
module tb_dcache_req_ctrl;
  import clap_mem_pkg::*;

  logic              clk, rst;
  logic              lsu_req, lsu_op, lsu_atom;
  logic [31:0]       lsu_addr, lsu_wdata;
  logic [3:0]        lsu_wstrb;
  logic              lsu_ready, lsu_done;
  logic [31:0]       lsu_rdata;
  logic [EXP_W-1:0]  lsu_exp;
  logic              cacop_req;
  logic [31:0]       cacop_addr;
  logic [CODE_W-1:0] cacop_code;
  logic              cacop_ready, cacop_done;
  logic              flush, llbit_clr, llbit;
  logic              c_valid, c_op, c_atom, c_cacop;
  logic [31:0]       c_addr, c_wdata;
  logic [3:0]        c_wstrb;
  logic [CODE_W-1:0] c_cacop_code;
  logic              c_accept, c_data_valid;
  logic [31:0]       c_rdata;
  logic [EXP_W-1:0]  c_exception;
  logic              stall;

  int   checks = 0;
  int   errors = 0;
  logic ll_m;

  typedef struct {
    logic        op, atom;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          acc_lat, dat_lat;
    logic [31:0] rin;
    logic [6:0]  ein;
    logic        clr;
  } txn_t;

  typedef struct {
    int          ready_wait, n_done, done_at;
    logic [31:0] rd;
    logic [6:0]  ex;
    logic        saw_valid, valid_ok, busy_ok, stall_done;
  } obs_t;

  dcache_req_ctrl dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_op(lsu_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_atom(lsu_atom), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .lsu_exp(lsu_exp),
    .cacop_req(cacop_req), .cacop_addr(cacop_addr), .cacop_code(cacop_code),
    .cacop_ready(cacop_ready), .cacop_done(cacop_done),
    .flush(flush), .llbit_clr(llbit_clr), .llbit(llbit),
    .c_valid(c_valid), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_atom(c_atom), .c_cacop(c_cacop), .c_cacop_code(c_cacop_code),
    .c_accept(c_accept), .c_data_valid(c_data_valid), .c_rdata(c_rdata),
    .c_exception(c_exception), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_req = 0; lsu_op = 0; lsu_atom = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wstrb = 0;
    cacop_req = 0; cacop_addr = 0; cacop_code = 0; flush = 0; llbit_clr = 0;
    c_accept = 0; c_data_valid = 0; c_rdata = 0; c_exception = 0;
  endtask

  function automatic logic [121:0] all_outputs();
    return {lsu_ready, lsu_done, lsu_rdata, lsu_exp, cacop_ready, cacop_done, llbit,
            c_valid, c_op, c_addr, c_wdata, c_wstrb, c_atom, c_cacop, c_cacop_code, stall};
  endfunction

  function automatic txn_t mk(logic op, logic atom, logic [31:0] addr, logic [31:0] wdata,
                              int acc_lat, int dat_lat, logic [31:0] rin, logic [6:0] ein, logic clr);
    txn_t t;
    t.op = op; t.atom = atom; t.addr = addr; t.wdata = wdata; t.wstrb = 4'hF;
    t.acc_lat = acc_lat; t.dat_lat = dat_lat; t.rin = rin; t.ein = ein; t.clr = clr;
    return t;
  endfunction

  // Reference model: architectural outcome of one LSU access.
  function automatic logic sc_fails(txn_t t, logic ll);
    return t.op && t.atom && !ll;
  endfunction

  function automatic logic [31:0] model_rdata(txn_t t, logic ll);
    if (t.op && t.atom) return (ll && t.ein == 0) ? 32'd1 : 32'd0;
    if (t.ein != 0) return 32'd0;
    return t.rin;
  endfunction

  function automatic logic model_ll(txn_t t, logic ll);
    if (sc_fails(t, ll)) return 1'b0;
    if (t.clr) return 1'b0;
    if (t.ein != 0) return ll;
    if (t.op && t.atom) return 1'b0;
    if (t.atom) return 1'b1;
    return ll;
  endfunction

  function automatic int model_done_at(txn_t t, logic ll);
    return sc_fails(t, ll) ? 1 : 1 + t.acc_lat + t.dat_lat;
  endfunction

  // Drives one LSU access and plays the cache side; called at posedge+1.
  task automatic run_lsu(input txn_t t, output obs_t o);
    int   acc_cnt, resp_t;
    logic accepted;
    lsu_req = 1; lsu_op = t.op; lsu_atom = t.atom; lsu_addr = t.addr;
    lsu_wdata = t.wdata; lsu_wstrb = t.wstrb;
    o.ready_wait = -1; o.n_done = 0; o.done_at = -1; o.rd = '0; o.ex = '0;
    o.saw_valid = 0; o.valid_ok = 1; o.busy_ok = 1; o.stall_done = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (lsu_ready) begin
        o.ready_wait = i;
        if (!stall) o.busy_ok = 0;
        break;
      end
      cyc();
    end
    if (o.ready_wait < 0) begin
      cyc();
      idle_inputs();
      return;
    end
    acc_cnt = 0; accepted = 0; resp_t = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      lsu_req = 0; c_accept = 0; c_data_valid = 0; c_exception = 0; c_rdata = 0; llbit_clr = 0;
      if (c_valid) begin
        if (accepted) o.valid_ok = 0;
        else begin
          o.saw_valid = 1;
          if (c_addr !== t.addr || c_op !== t.op || c_atom !== t.atom || c_cacop !== 1'b0 ||
              c_wdata !== t.wdata || c_wstrb !== t.wstrb) o.valid_ok = 0;
          if (acc_cnt == t.acc_lat) begin
            c_accept = 1; accepted = 1; resp_t = k + t.dat_lat;
          end else acc_cnt++;
        end
      end
      if (k == resp_t) begin
        c_data_valid = (t.ein == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        c_rdata = t.rin; c_exception = t.ein; llbit_clr = t.clr;
      end
      #1;
      if (lsu_done) begin
        o.n_done++; o.done_at = k; o.rd = lsu_rdata; o.ex = lsu_exp; o.stall_done = stall;
      end else if (o.n_done == 0 && !stall) o.busy_ok = 0;
    end
    cyc();
    idle_inputs();
  endtask

  // Checks one observed LSU access against the model and advances it.
  task automatic check_txn(input string tag, input txn_t t, input obs_t o);
    logic [31:0] e_rd;
    logic        e_ll;
    e_rd = model_rdata(t, ll_m);
    e_ll = model_ll(t, ll_m);
    checks++;
    if (o.ready_wait != 0 || o.n_done != 1) begin
      errors++;
      $display("FAIL %s_handshake: ready_wait %0d done_count %0d, required 0 and 1", tag, o.ready_wait, o.n_done);
    end
    checks++;
    if (o.rd !== e_rd || o.ex !== (sc_fails(t, ll_m) ? 7'h0 : t.ein)) begin
      errors++;
      $display("FAIL %s_result: rdata %h exp %h, required %h %h", tag, o.rd, o.ex, e_rd,
               sc_fails(t, ll_m) ? 7'h0 : t.ein);
    end
    checks++;
    if (o.done_at != model_done_at(t, ll_m)) begin
      errors++;
      $display("FAIL %s_latency: done at %0d, required %0d", tag, o.done_at, model_done_at(t, ll_m));
    end
    checks++;
    if (!o.valid_ok || o.saw_valid !== !sc_fails(t, ll_m)) begin
      errors++;
      $display("FAIL %s_cache_req: fields_ok %0b saw_valid %0b, required 1 and %0b", tag, o.valid_ok,
               o.saw_valid, !sc_fails(t, ll_m));
    end
    ll_m = e_ll;
    checks++;
    if (llbit !== ll_m) begin
      errors++;
      $display("FAIL %s_llbit: got %0b required %0b", tag, llbit, ll_m);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) cyc();
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_outputs());
    end
    rst = 0;
    ll_m = 0;
    cyc();
    checks++;
    if (c_valid !== 1'b0 || llbit !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: c_valid %0b llbit %0b stall %0b required 0 0 0", c_valid, llbit, stall);
    end
  endtask

  task automatic test_load();
    txn_t t;
    obs_t o;
    t = mk(0, 0, 32'h1000, 32'h0, 2, 3, 32'hDEADBEEF, 7'h0, 0);
    run_lsu(t, o);
    check_txn("load", t, o);
    checks++;
    if (o.busy_ok !== 1'b1 || o.stall_done !== 1'b0) begin
      errors++;
      $display("FAIL load_stall: busy_ok %0b stall_at_done %0b required 1 0", o.busy_ok, o.stall_done);
    end
  endtask

  task automatic test_llsc();
    txn_t t;
    obs_t o;
    t = mk(0, 1, 32'h20, 32'h0, 1, 1, 32'h5A5A5A5A, 7'h0, 0);
    run_lsu(t, o);
    check_txn("ll", t, o);
    t = mk(1, 1, 32'h20, 32'h11112222, 0, 2, 32'h0, 7'h0, 0);
    run_lsu(t, o);
    check_txn("sc_ok", t, o);
    t = mk(1, 1, 32'h20, 32'h33334444, 0, 2, 32'h0, 7'h0, 0);
    run_lsu(t, o);
    check_txn("sc_fail", t, o);
  endtask

  task automatic test_exception();
    txn_t t;
    obs_t o;
    t = mk(0, 1, 32'h60, 32'h0, 1, 2, 32'h77777777, 7'h04, 0);
    run_lsu(t, o);
    check_txn("ll_exc", t, o);
  endtask

  task automatic test_llbit_clr();
    txn_t t;
    obs_t o;
    t = mk(0, 1, 32'h24, 32'h0, 0, 1, 32'h1, 7'h0, 1);
    run_lsu(t, o);
    check_txn("ll_clr_same", t, o);
    t = mk(0, 1, 32'h24, 32'h0, 0, 1, 32'h2, 7'h0, 0);
    run_lsu(t, o);
    check_txn("ll_set", t, o);
    llbit_clr = 1;
    cyc();
    llbit_clr = 0;
    ll_m = 0;
    checks++;
    if (llbit !== 1'b0) begin
      errors++;
      $display("FAIL llbit_clr: got %0b required 0", llbit);
    end
  endtask

  task automatic test_arbitration();
    txn_t t;
    obs_t o;
    logic got, accepted, ok;
    lsu_req = 1; lsu_op = 0; lsu_atom = 0; lsu_addr = 32'h500; lsu_wdata = 0; lsu_wstrb = 4'hF;
    cacop_req = 1; cacop_addr = 32'h700; cacop_code = 5'h0B;
    #1;
    checks++;
    if (cacop_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_grant: cacop_ready %0b lsu_ready %0b required 1 0", cacop_ready, lsu_ready);
    end
    cyc();
    cacop_req = 0;
    got = 0; accepted = 0; ok = 1;
    for (int i = 0; i < 20; i++) begin
      c_accept = 0; c_data_valid = 0;
      if (accepted) c_data_valid = 1;
      else if (c_valid) begin
        if (c_cacop !== 1'b1 || c_addr !== 32'h700 || c_cacop_code !== 5'h0B) ok = 0;
        c_accept = 1; accepted = 1;
      end
      #1;
      if (lsu_ready || lsu_done) ok = 0;
      if (cacop_done) begin
        got = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (got !== 1'b1 || ok !== 1'b1) begin
      errors++;
      $display("FAIL arb_cacop: done %0b lsu_quiet_fields_ok %0b required 1 1", got, ok);
    end
    cyc();
    c_data_valid = 0;
    t = mk(0, 0, 32'h500, 32'h0, 1, 1, 32'hCAFE0001, 7'h0, 0);
    run_lsu(t, o);
    check_txn("arb_lsu", t, o);
  endtask

  task automatic test_flush();
    txn_t t;
    obs_t o;
    // Flush one cycle after acceptance: the access drains silently.
    lsu_req = 1; lsu_op = 0; lsu_atom = 0; lsu_addr = 32'h300; lsu_wdata = 0; lsu_wstrb = 4'hF;
    cyc();
    lsu_req = 0;
    c_accept = 1;
    cyc();
    c_accept = 0;
    flush = 1;
    #1;
    checks++;
    if (lsu_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_done: got %0b required 0", lsu_done);
    end
    cyc();
    flush = 0;
    lsu_req = 1; lsu_addr = 32'h304;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        c_data_valid = 1; c_rdata = 32'h12345678;
      end
      #1;
      checks++;
      if ({c_valid, lsu_ready, lsu_done} !== 3'b000) begin
        errors++;
        $display("FAIL flush_drain_%0d: valid/ready/done %b required 000", i, {c_valid, lsu_ready, lsu_done});
      end
      cyc();
      c_data_valid = 0; c_rdata = 0;
    end
    t = mk(0, 0, 32'h304, 32'h0, 0, 2, 32'h0BADF00D, 7'h0, 0);
    run_lsu(t, o);
    check_txn("after_drain", t, o);
    // Flush before acceptance, then flush while idle with a request pending.
    lsu_req = 1; lsu_addr = 32'h400;
    cyc();
    lsu_req = 0;
    flush = 1;
    #1;
    checks++;
    if (c_valid !== 1'b1 || lsu_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: c_valid %0b done %0b required 1 0", c_valid, lsu_done);
    end
    cyc();
    flush = 0;
    checks++;
    if (c_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_idle: c_valid %0b required 0", c_valid);
    end
    lsu_req = 1; lsu_addr = 32'h404; flush = 1;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready: got %0b required 0", lsu_ready);
    end
    cyc();
    flush = 0;
    t = mk(1, 0, 32'h404, 32'hA5A5A5A5, 1, 1, 32'h0, 7'h0, 0);
    run_lsu(t, o);
    check_txn("after_flush_req", t, o);
  endtask

  task automatic test_reset_mid_wait();
    txn_t t;
    obs_t o;
    t = mk(0, 1, 32'h80, 32'h0, 0, 1, 32'h1, 7'h0, 0);
    run_lsu(t, o);
    check_txn("pre_rst_ll", t, o);
    lsu_req = 1; lsu_op = 0; lsu_atom = 0; lsu_addr = 32'h84; lsu_wdata = 32'h99; lsu_wstrb = 4'hF;
    cyc();
    lsu_req = 0;
    c_accept = 1;
    cyc();
    c_accept = 0;
    rst = 1;
    cyc();
    c_data_valid = 1; c_rdata = 32'h55555555;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL rst_mid_wait: got %h required 0", all_outputs());
    end
    cyc();
    c_data_valid = 0; c_rdata = 0;
    rst = 0;
    ll_m = 0;
    cyc();
  endtask

  task automatic test_random();
    txn_t t;
    obs_t o;
    for (int n = 0; n < 30; n++) begin
      t.op = 1'($urandom_range(0, 1));
      t.atom = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      t.addr = $urandom & 32'hFFFF_FFFC;
      t.wdata = $urandom;
      t.wstrb = 4'($urandom_range(1, 15));
      t.acc_lat = $urandom_range(0, 4);
      t.dat_lat = $urandom_range(1, 4);
      t.rin = $urandom;
      t.ein = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(1, 127)) : 7'h0;
      t.clr = ($urandom_range(0, 7) == 0);
      run_lsu(t, o);
      check_txn($sformatf("rand%0d", n), t, o);
      if ($urandom_range(0, 5) == 0) begin
        llbit_clr = 1;
        cyc();
        llbit_clr = 0;
        ll_m = 0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    ll_m = 0;
    cyc();
    test_reset();
    test_load();
    test_llsc();
    test_exception();
    test_llbit_clr();
    test_arbitration();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
